risc_v_mike_mmio_timer: RTL and testbench
=========================================

Name: risc_v_mike_mmio_timer

Overview:
- Memory-mapped timer/compare peripheral. It is a responder on the core's MMIO data bus, alongside the GPIO block.
- The core issues single-cycle loads and stores. This block decodes a 32-byte window and returns read data combinationally within the same cycle. Writes commit at the next clock edge.
- Provides a prescaled 32-bit up-counter, compare match, overflow detection, and a level interrupt output.

Parameters:
- BASE_ADDR, 32'hFFFF0040: byte base address of the register window. Must be 32-byte aligned.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- data_mmio_addr  input  32  byte address from the memory controller
- data_mmio_wr_addr_val  input  1  store strobe, valid for one cycle
- data_mmio_rd_addr_val  input  1  load strobe; address is in the MMIO region
- data_mmio_wr_data  input  32  store data
- data_mmio_rd_data  output  32  load data (combinational)
- data_mmio_hit  output  1  data_mmio_addr[31:5] == BASE_ADDR[31:5]
- timer_irq  output  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Register map (offset = addr[4:2]; addr[1:0] ignored):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bit3 ONESHOT. Bits 31:4 read 0.
  - 0x04 PRESCALE [31:0]
  - 0x08 COUNT [31:0]
  - 0x0C COMPARE [31:0]
  - 0x10 STATUS: bit0 MATCH, bit1 OVF. Write-1-to-clear. Other bits read 0.
  - 0x14–0x1C: reserved. Reads return 0; writes are ignored.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFFFFFF, STATUS=0, internal pcnt=0. Consequently timer_irq=0, and data_mmio_rd_data=0 when no read is active.
- Read path: data_mmio_rd_data = selected register when data_mmio_rd_addr_val & data_mmio_hit, else 32'h0. Zero latency. Reads have no side effects.
- Write path: a write is accepted when data_mmio_wr_addr_val & data_mmio_hit. The register updates at the next rising clk edge.
- Prescaler:
  - When EN=1, pcnt increments every cycle.
  - When pcnt == PRESCALE, tick=1 for that cycle and pcnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - When EN=0, pcnt is held at 0 and tick=0.
- On each tick:
  - If COUNT == COMPARE: set MATCH. COUNT becomes 0 if AUTO_RELOAD=1, otherwise COUNT+1. If ONESHOT=1, EN is cleared.
  - Else if COUNT == 32'hFFFFFFFF: COUNT wraps to 0 and OVF is set.
  - Else: COUNT = COUNT+1.
  - With AUTO_RELOAD=1, the match period is (COMPARE+1)*(PRESCALE+1) cycles.
  - Arithmetic is unsigned modulo 2^32.
- timer_irq = IRQ_EN & (MATCH | OVF). It is combinational from registered state only, so it is glitch-free. It stays high until software clears the cause with a W1C write.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the written value wins, pcnt is cleared, and no match/overflow is evaluated that cycle.
  - Write to PRESCALE: pcnt is cleared.
  - W1C of a STATUS bit in the same cycle as a hardware set of that bit: the set wins and the bit stays 1.
  - Write to CTRL clearing EN in the same cycle as a tick: the tick's COUNT/STATUS update still occurs; the counter is frozen from the next cycle.
  - ONESHOT clearing EN in the same cycle as a software CTRL write: the software write wins.
- rst asserted mid-count: all state returns to reset values at that edge. The first tick after release needs EN to be set again.
- Addresses outside the window: no register changes, data_mmio_hit=0, read data is 0.

Test Plan:
- Reset then read: assert rst 2 cycles; read 0x00/0x04/0x08/0x0C/0x10 → 0, 0, 0, 32'hFFFFFFFF, 0. timer_irq=0.
- Periodic match: PRESCALE=3, COMPARE=4, CTRL=0x7 → MATCH first sets 20 cycles after the CTRL write, timer_irq=1. After W1C STATUS=1, it re-asserts 20 cycles later.
- Overflow: COUNT=32'hFFFFFFFE, COMPARE=5, PRESCALE=0, CTRL=0x5 → COUNT reads 0 after 2 ticks, OVF=1, timer_irq=1, MATCH=0.
- One-shot: COMPARE=2, PRESCALE=0, CTRL=0x9 → MATCH=1 and EN reads 0 on the 3rd tick. COUNT then holds at 3 for 50 cycles.
- Collisions: a W1C of MATCH in the same cycle as a new match → MATCH stays 1. A write COUNT=100 coinciding with a tick → COUNT reads 100, pcnt restarts.
- Decode: store to BASE_ADDR+0x20 and to 0xFFFF0000 → no register change, data_mmio_hit=0. A load of 0x14 inside the window → 0.

Source files
------------

// File: rtl/risc_v_mike_mmio_timer.sv
// risc_v_mike_mmio_timer: MMIO prescaled 32-bit timer with compare match, overflow and level irq
module risc_v_mike_mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_mmio_addr,
  input  logic        data_mmio_wr_addr_val,
  input  logic        data_mmio_rd_addr_val,
  input  logic [31:0] data_mmio_wr_data,
  output logic [31:0] data_mmio_rd_data,
  output logic        data_mmio_hit,
  output logic        timer_irq
);
  logic [3:0]  r_ctrl;
  logic [31:0] r_prescale;
  logic [31:0] r_pcnt;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [1:0]  r_status;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_prescale;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_eval;
  logic        w_match;
  logic        w_ovf;
  logic        w_unused;
  assign w_unused      = &{1'b0, data_mmio_addr[1:0]};
  assign data_mmio_hit = data_mmio_addr[31:5] == BASE_ADDR[31:5];
  assign w_off         = data_mmio_addr[4:2];
  assign w_wr          = data_mmio_wr_addr_val & data_mmio_hit;
  assign w_wr_ctrl     = w_wr && w_off == 3'd0;
  assign w_wr_prescale = w_wr && w_off == 3'd1;
  assign w_wr_count    = w_wr && w_off == 3'd2;
  assign w_wr_compare  = w_wr && w_off == 3'd3;
  assign w_wr_status   = w_wr && w_off == 3'd4;
  // A software COUNT write suppresses match/overflow evaluation for that tick.
  assign w_tick  = r_ctrl[0] && r_pcnt == r_prescale;
  assign w_eval  = w_tick && !w_wr_count;
  assign w_match = w_eval && r_count == r_compare;
  assign w_ovf   = w_eval && r_count != r_compare && &r_count;
  assign timer_irq = r_ctrl[2] & |r_status;
  // Zero-latency read mux; unselected or reserved offsets read as zero.
  always_comb begin
    data_mmio_rd_data = !(data_mmio_rd_addr_val && data_mmio_hit) ? 32'h0 :
                        w_off == 3'd0 ? {28'h0, r_ctrl} :
                        w_off == 3'd1 ? r_prescale :
                        w_off == 3'd2 ? r_count :
                        w_off == 3'd3 ? r_compare :
                        w_off == 3'd4 ? {30'h0, r_status} : 32'h0;
  end
  // Register state: software writes take priority over hardware updates, except that hardware status sets beat W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= 4'h0;
      r_prescale <= 32'h0;
      r_pcnt     <= 32'h0;
      r_count    <= 32'h0;
      r_compare  <= 32'hFFFFFFFF;
      r_status   <= 2'b00;
    end else begin
      r_pcnt     <= (!r_ctrl[0] || w_wr_prescale || w_wr_count || w_tick) ? 32'h0 : r_pcnt + 32'd1;
      r_ctrl     <= w_wr_ctrl ? data_mmio_wr_data[3:0] : (w_match && r_ctrl[3]) ? (r_ctrl & 4'b1110) : r_ctrl;
      r_prescale <= w_wr_prescale ? data_mmio_wr_data : r_prescale;
      r_compare  <= w_wr_compare ? data_mmio_wr_data : r_compare;
      r_count    <= w_wr_count ? data_mmio_wr_data : (w_match && r_ctrl[1]) ? 32'h0 : w_tick ? r_count + 32'd1 : r_count;
      r_status   <= (r_status & ~(w_wr_status ? data_mmio_wr_data[1:0] : 2'b00)) | {w_ovf, w_match};
    end
  end
endmodule

// File: tb/tb_risc_v_mike_mmio_timer.sv
// tb_risc_v_mike_mmio_timer: directed self-checking bench for the MMIO timer
module tb_risc_v_mike_mmio_timer;
  localparam logic [31:0] B = 32'hFFFF0040;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        wr_val = 1'b0;
  logic        rd_val = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;
  int          n_pass = 0;
  int          n_chk = 0;
  risc_v_mike_mmio_timer #(.BASE_ADDR(B)) dut (
    .clk(clk),
    .rst(rst),
    .data_mmio_addr(addr),
    .data_mmio_wr_addr_val(wr_val),
    .data_mmio_rd_addr_val(rd_val),
    .data_mmio_wr_data(wdata),
    .data_mmio_rd_data(rdata),
    .data_mmio_hit(hit),
    .timer_irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    wr_val = 1'b1;
    @(posedge clk);
    #1;
    wr_val = 1'b0;
  endtask
  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    rd_val = 1'b1;
    #1;
    check(tag, rdata, exp);
    rd_val = 1'b0;
  endtask
  task automatic hchk(input string tag, input logic [31:0] a, input logic exp);
    addr = a;
    #1;
    check(tag, {31'h0, hit}, {31'h0, exp});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    rchk("rst_ctrl", B, 32'h0);
    rchk("rst_pre", B + 4, 32'h0);
    rchk("rst_cnt", B + 8, 32'h0);
    rchk("rst_cmp", B + 12, 32'hFFFFFFFF);
    rchk("rst_sts", B + 16, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    tick(1);
    wr(B + 4, 3);
    wr(B + 12, 4);
    wr(B, 7);
    tick(19);
    rchk("per_pre", B + 16, 32'h0);
    check("per_irq_pre", {31'h0, irq}, 32'h0);
    tick(1);
    rchk("per_match", B + 16, 32'h1);
    check("per_irq", {31'h0, irq}, 32'h1);
    rchk("per_reload", B + 8, 32'h0);
    wr(B + 16, 1);
    rchk("per_w1c", B + 16, 32'h0);
    check("per_irq_clr", {31'h0, irq}, 32'h0);
    tick(18);
    rchk("per2_pre", B + 16, 32'h0);
    tick(1);
    rchk("per2_match", B + 16, 32'h1);
    wr(B + 16, 1);
    tick(18);
    rchk("coll_pre", B + 16, 32'h0);
    wr(B + 16, 1);
    rchk("coll_w1c_set", B + 16, 32'h1);
    wr(B, 0);
    wr(B + 16, 3);
    wr(B + 4, 0);
    wr(B + 12, 5);
    wr(B + 8, 32'hFFFFFFFE);
    wr(B, 5);
    tick(1);
    rchk("ovf_cnt1", B + 8, 32'hFFFFFFFF);
    tick(1);
    rchk("ovf_cnt0", B + 8, 32'h0);
    rchk("ovf_sts", B + 16, 32'h2);
    check("ovf_irq", {31'h0, irq}, 32'h1);
    wr(B, 0);
    wr(B + 16, 3);
    check("ovf_irq_clr", {31'h0, irq}, 32'h0);
    wr(B + 8, 0);
    wr(B + 12, 2);
    wr(B, 9);
    tick(2);
    rchk("os_sts0", B + 16, 32'h0);
    rchk("os_cnt2", B + 8, 32'h2);
    tick(1);
    rchk("os_match", B + 16, 32'h1);
    rchk("os_ctrl", B, 32'h8);
    rchk("os_cnt3", B + 8, 32'h3);
    tick(50);
    rchk("os_hold", B + 8, 32'h3);
    wr(B + 16, 3);
    wr(B + 4, 2);
    wr(B + 12, 1000);
    wr(B + 8, 0);
    wr(B, 1);
    tick(5);
    rchk("cw_cnt1", B + 8, 32'h1);
    wr(B + 8, 100);
    rchk("cw_cnt100", B + 8, 32'd100);
    tick(2);
    rchk("cw_hold", B + 8, 32'd100);
    tick(1);
    rchk("cw_cnt101", B + 8, 32'd101);
    wr(B + 4, 2);
    tick(2);
    rchk("pre_restart", B + 8, 32'd101);
    tick(1);
    rchk("pre_tick", B + 8, 32'd102);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rchk("mid_rst_ctrl", B, 32'h0);
    rchk("mid_rst_cnt", B + 8, 32'h0);
    rchk("mid_rst_cmp", B + 12, 32'hFFFFFFFF);
    tick(5);
    rchk("mid_rst_frozen", B + 8, 32'h0);
    wr(B + 32'h20, 32'hF);
    wr(32'hFFFF0000, 32'hF);
    wr(B + 32'h14, 32'hF);
    rchk("dec_ctrl", B, 32'h0);
    hchk("dec_hit_20", B + 32'h20, 1'b0);
    hchk("dec_hit_low", 32'hFFFF0000, 1'b0);
    hchk("dec_hit_14", B + 32'h14, 1'b1);
    rchk("dec_rsvd", B + 32'h14, 32'h0);
    rchk("dec_out_rd", 32'hFFFF000C, 32'h0);
    addr = B + 12;
    #1;
    check("no_rd_zero", rdata, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
